// File: rtl/panda_shifter_unit.sv
// Registered barrel shifter for the Panda Core execute stage: logical left, logical right
// and arithmetic right by 0..Width-1. Optional rotate support under PANDA_SHIFTER_ROTATE_EN.
module panda_shifter_unit #(
    parameter int Width = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    input  logic                     left_i,
    input  logic                     arithmetic_i,
    input  logic [Width-1:0]         operand_i,
    input  logic [$clog2(Width)-1:0] amount_i,
`ifdef PANDA_SHIFTER_ROTATE_EN
    input  logic                     rotate_i,
`endif
    output logic [Width-1:0]         result_o,
    output logic                     valid_o
);

    localparam int AmtW = $clog2(Width);

    // stage_s[k] is the operand after the first k barrel stages
    logic [AmtW:0][Width-1:0] stage_s;
    logic                     fill_s;

    // Vacated MSBs take the sign bit only for arithmetic right shifts
    assign fill_s     = ~left_i & arithmetic_i & operand_i[Width-1];
    assign stage_s[0] = operand_i;

    for (genvar k = 0; k < AmtW; k++) begin : g_stage
        localparam int Dist = 1 << k;

        logic [Width-1:0] shl_s;
        logic [Width-1:0] shr_s;
        logic [Width-1:0] shift_s;

        assign shl_s = {stage_s[k][Width-1-Dist:0], {Dist{1'b0}}};
        assign shr_s = {{Dist{fill_s}}, stage_s[k][Width-1:Dist]};

`ifdef PANDA_SHIFTER_ROTATE_EN
        logic [Width-1:0] rotl_s;
        logic [Width-1:0] rotr_s;

        assign rotl_s  = {stage_s[k][Width-1-Dist:0], stage_s[k][Width-1:Width-Dist]};
        assign rotr_s  = {stage_s[k][Dist-1:0], stage_s[k][Width-1:Dist]};
        assign shift_s = rotate_i ? (left_i ? rotl_s : rotr_s)
                                  : (left_i ? shl_s  : shr_s);
`else
        assign shift_s = left_i ? shl_s : shr_s;
`endif

        assign stage_s[k+1] = amount_i[k] ? shift_s : stage_s[k];
    end

    // Output register: load on valid, hold result otherwise; valid is a one-cycle pulse per op
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_o <= {Width{1'b0}};
            valid_o  <= 1'b0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                result_o <= stage_s[AmtW];
            end else begin
                result_o <= result_o;
            end
        end
    end

endmodule

// File: tb/tb_panda_shifter_unit.sv
// Self-checking bench for panda_shifter_unit: directed vector table, reset/back-to-back
// sequences and randomized operations against an arithmetic reference model.
module tb_panda_shifter_unit;

    localparam int W = 32;

    typedef struct {
        string       name;
        logic        left;
        logic        arith;
        logic        rot;
        logic [31:0] operand;
        logic [4:0]  amount;
        logic [31:0] expected;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        left_i;
    logic        arithmetic_i;
    logic        rot_v;
    logic [31:0] operand_i;
    logic [4:0]  amount_i;
    logic [31:0] result_o;
    logic        valid_o;

    int errors = 0;
    int checks = 0;

    vec_t        vecs[$];
    logic [31:0] exp_result;
    logic        exp_valid;

    panda_shifter_unit #(.Width(W)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .left_i       (left_i),
        .arithmetic_i (arithmetic_i),
        .operand_i    (operand_i),
        .amount_i     (amount_i),
`ifdef PANDA_SHIFTER_ROTATE_EN
        .rotate_i     (rot_v),
`endif
        .result_o     (result_o),
        .valid_o      (valid_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input string n, input logic l, input logic a, input logic r,
                                input logic [31:0] op, input logic [4:0] amt,
                                input logic [31:0] e);
        vec_t v;
        v.name = n; v.left = l; v.arith = a; v.rot = r;
        v.operand = op; v.amount = amt; v.expected = e;
        return v;
    endfunction

    // Reference model: plain shift operators on 32/64-bit values
    function automatic logic [31:0] ref_shift(input logic l, input logic a, input logic r,
                                              input logic [31:0] op, input int amt);
        logic        [63:0] dbl;
        logic signed [31:0] sop;
        dbl = {op, op};
        sop = op;
        if (r) begin
            if (l) begin
                dbl = dbl << amt;
                return dbl[63:32];
            end
            dbl = dbl >> amt;
            return dbl[31:0];
        end
        if (l) return op << amt;
        if (a) return sop >>> amt;
        return op >> amt;
    endfunction

    task automatic check32(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, req);
        end
    endtask

    task automatic check1(input string n, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b", n, act, req);
        end
    endtask

    task automatic drive(input logic v, input logic l, input logic a, input logic r,
                         input logic [31:0] op, input logic [4:0] amt);
        valid_i = v; left_i = l; arithmetic_i = a; rot_v = r;
        operand_i = op; amount_i = amt;
    endtask

    initial begin
        vecs.push_back(mk("rl_amt0",    1'b0, 1'b0, 1'b0, 32'h0034543B, 5'd0,  32'h0034543B));
        vecs.push_back(mk("rl_amt5",    1'b0, 1'b0, 1'b0, 32'h0034543B, 5'd5,  32'h0001A2A1));
        vecs.push_back(mk("ra_amt5",    1'b0, 1'b1, 1'b0, 32'h0034543B, 5'd5,  32'h0001A2A1));
        vecs.push_back(mk("l_amt5",     1'b1, 1'b0, 1'b0, 32'h0034543B, 5'd5,  32'h068A8760));
        vecs.push_back(mk("rl_neg8",    1'b0, 1'b0, 1'b0, 32'hFFBD7FA6, 5'd8,  32'h00FFBD7F));
        vecs.push_back(mk("ra_neg8",    1'b0, 1'b1, 1'b0, 32'hFFBD7FA6, 5'd8,  32'hFFFFBD7F));
        vecs.push_back(mk("l_neg8",     1'b1, 1'b0, 1'b0, 32'hFFBD7FA6, 5'd8,  32'hBD7FA600));
        vecs.push_back(mk("l_amt24",    1'b1, 1'b0, 1'b0, 32'hFFBD7FA6, 5'd24, 32'hA6000000));
        vecs.push_back(mk("ra_amt31",   1'b0, 1'b1, 1'b0, 32'h80000000, 5'd31, 32'hFFFFFFFF));
        vecs.push_back(mk("rl_amt31",   1'b0, 1'b0, 1'b0, 32'h80000000, 5'd31, 32'h00000001));
        vecs.push_back(mk("l_arith_ig", 1'b1, 1'b1, 1'b0, 32'h80000001, 5'd1,  32'h00000002));
`ifdef PANDA_SHIFTER_ROTATE_EN
        vecs.push_back(mk("rotl_4",     1'b1, 1'b0, 1'b1, 32'h80000001, 5'd4,  32'h00000018));
        vecs.push_back(mk("rotr_4",     1'b0, 1'b0, 1'b1, 32'h80000001, 5'd4,  32'h18000000));
        vecs.push_back(mk("rotr_arith", 1'b0, 1'b1, 1'b1, 32'h80000001, 5'd4,  32'h18000000));
`endif

        // Power-on reset
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
        #1;
        check32("reset_result", result_o, 32'h0);
        check1("reset_valid", valid_o, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;

        // Directed table
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(1'b1, vecs[i].left, vecs[i].arith, vecs[i].rot, vecs[i].operand, vecs[i].amount);
            @(posedge clk);
            #1;
            check32({vecs[i].name, "_result"}, result_o, vecs[i].expected);
            check1({vecs[i].name, "_valid"}, valid_o, 1'b1);
        end

        // Reset mid-operation: clears immediately, in-flight op discarded
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFBD7FA6, 5'd8);
        @(posedge clk);
        #1;
        check32("pre_reset_result", result_o, 32'hBD7FA600);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0034543B, 5'd5);
        #2;
        rst_i = 1'b1;
        #1;
        check32("async_reset_result", result_o, 32'h0);
        check1("async_reset_valid", valid_o, 1'b0);
        @(posedge clk);
        #1;
        check32("held_reset_result", result_o, 32'h0);
        check1("held_reset_valid", valid_o, 1'b0);
        @(negedge clk);
        rst_i = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678, 5'd3);
        @(posedge clk);
        #1;
        check32("post_reset_idle_result", result_o, 32'h0);
        check1("post_reset_idle_valid", valid_o, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0034543B, 5'd5);
        @(posedge clk);
        #1;
        check32("first_after_reset_result", result_o, 32'h0001A2A1);
        check1("first_after_reset_valid", valid_o, 1'b1);

        // Back-to-back issue then hold
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h00000001, 5'd31);
        @(posedge clk);
        #1;
        check32("b2b_0_result", result_o, 32'h80000000);
        check1("b2b_0_valid", valid_o, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hF0000000, 5'd4);
        @(posedge clk);
        #1;
        check32("b2b_1_result", result_o, 32'hFF000000);
        check1("b2b_1_valid", valid_o, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 5'd16);
        @(posedge clk);
        #1;
        check32("b2b_2_result", result_o, 32'h0000DEAD);
        check1("b2b_2_valid", valid_o, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 5'd1);
        @(posedge clk);
        #1;
        check32("hold_result", result_o, 32'h0000DEAD);
        check1("hold_valid", valid_o, 1'b0);

        // Randomized operations against the reference model
        exp_result = 32'h0000DEAD;
        for (int n = 0; n < 300; n++) begin
            logic        v;
            logic        l;
            logic        a;
            logic        r;
            logic [31:0] op;
            logic [4:0]  amt;
            v   = ($urandom_range(0, 3) != 0);
            l   = $urandom_range(0, 1) != 0;
            a   = $urandom_range(0, 1) != 0;
`ifdef PANDA_SHIFTER_ROTATE_EN
            r   = $urandom_range(0, 2) == 0;
`else
            r   = 1'b0;
`endif
            op  = $urandom;
            amt = 5'($urandom_range(0, 31));
            @(negedge clk);
            drive(v, l, a, r, op, amt);
            if (v) exp_result = ref_shift(l, a, r, op, int'(amt));
            exp_valid = v;
            @(posedge clk);
            #1;
            check32("rand_result", result_o, exp_result);
            check1("rand_valid", valid_o, exp_valid);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
